// File: rtl/ex_stage_mcq.sv
// Execute-stage output register with an in-order parking queue
// for multi-cycle XALU instructions (mul/div/madd).
module ex_stage_mcq #(
   parameter int DATA_W = 32,
   parameter int PAYLOAD_W = 128,
   parameter int DEPTH = 2,
   parameter logic [PAYLOAD_W-1:0] BUBBLE = 128'h1
) (
   input  logic                         Clk,
   input  logic                         Clr,
   input  logic                         flush,
   input  logic                         stall,
   input  logic                         in_valid,
   input  logic                         in_mc,
   input  logic [PAYLOAD_W-1:0]         in_payload,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         xalu_done,
   input  logic [DATA_W-1:0]            xalu_result,
   output logic                         hold_req,
   output logic                         xalu_abort,
   output logic                         out_valid,
   output logic [PAYLOAD_W-1:0]         out_payload,
   output logic [DATA_W-1:0]            out_data,
   output logic [$clog2(DEPTH+1)-1:0]   park_count,
   output logic                         orphan_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [PAYLOAD_W-1:0] pl_q [DEPTH];
   logic [DATA_W-1:0]    dt_q [DEPTH];
   logic [DEPTH-1:0]     rdy_q;
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rdy_ptr;
   logic [CW-1:0]        count;
   logic [CW-1:0]        rdy_cnt;

   logic full;
   logic empty;
   logic head_rdy;
   logic push;
   logic res_wr;
   logic orphan;
   logic pop;
   logic load;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign head_rdy = rdy_q[rd_ptr];

   // A slot freed by this cycle's pop is not reusable until next cycle.
   assign push   = in_valid & in_mc & ~full;
   assign res_wr = xalu_done & (rdy_cnt != count);
   assign orphan = xalu_done & (rdy_cnt == count);
   assign pop    = ~stall & head_rdy;
   assign load   = ~stall & ~head_rdy & empty & in_valid & ~in_mc;

   assign hold_req = (in_valid & in_mc & full)
                   | (in_valid & ~in_mc & ~empty)
                   | (in_valid & ~in_mc & stall);

   assign xalu_abort = flush;
   assign park_count = count;

   always_ff @(posedge Clk) begin
      if (Clr) begin
         out_valid   <= 1'b0;
         out_payload <= BUBBLE;
         out_data    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         rdy_ptr     <= '0;
         count       <= '0;
         rdy_cnt     <= '0;
         rdy_q       <= '0;
         orphan_err  <= 1'b0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         out_payload <= BUBBLE;
         out_data    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         rdy_ptr     <= '0;
         count       <= '0;
         rdy_cnt     <= '0;
         rdy_q       <= '0;
      end else begin
         unique case (1'b1)
            pop: begin
               out_valid   <= 1'b1;
               out_payload <= pl_q[rd_ptr];
               out_data    <= dt_q[rd_ptr];
            end
            load: begin
               out_valid   <= 1'b1;
               out_payload <= in_payload;
               out_data    <= in_data;
            end
            stall: begin
            end
            default: begin
               out_valid   <= 1'b0;
               out_payload <= BUBBLE;
               out_data    <= '0;
            end
         endcase

         if (push) begin
            pl_q[wr_ptr]  <= in_payload;
            rdy_q[wr_ptr] <= 1'b0;
            wr_ptr        <= nxt(wr_ptr);
         end

         // Results fill the oldest waiting entry, keeping ready a prefix.
         if (res_wr) begin
            dt_q[rdy_ptr]  <= xalu_result;
            rdy_q[rdy_ptr] <= 1'b1;
            rdy_ptr        <= nxt(rdy_ptr);
         end

         if (pop) begin
            rdy_q[rd_ptr] <= 1'b0;
            rd_ptr        <= nxt(rd_ptr);
         end

         count   <= count + CW'(push) - CW'(pop);
         rdy_cnt <= rdy_cnt + CW'(res_wr) - CW'(pop);

         if (orphan) begin
            orphan_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage_mcq.sv
// Scoreboard bench for ex_stage_mcq: queue-level reference model,
// directed scenarios followed by randomized traffic.
module tb_ex_stage_mcq;

   localparam int D  = 32;
   localparam int P  = 128;
   localparam int N  = 2;
   localparam int CW = $clog2(N + 1);
   localparam logic [P-1:0] BUB = 128'h1;

   logic          Clk = 1'b0;
   logic          Clr = 1'b0;
   logic          flush = 1'b0;
   logic          stall = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_mc = 1'b0;
   logic [P-1:0]  in_payload = '0;
   logic [D-1:0]  in_data = '0;
   logic          xalu_done = 1'b0;
   logic [D-1:0]  xalu_result = '0;
   logic          hold_req;
   logic          xalu_abort;
   logic          out_valid;
   logic [P-1:0]  out_payload;
   logic [D-1:0]  out_data;
   logic [CW-1:0] park_count;
   logic          orphan_err;

   ex_stage_mcq #(
      .DATA_W(D), .PAYLOAD_W(P), .DEPTH(N), .BUBBLE(BUB)
   ) dut (
      .Clk(Clk), .Clr(Clr), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_mc(in_mc),
      .in_payload(in_payload), .in_data(in_data),
      .xalu_done(xalu_done), .xalu_result(xalu_result),
      .hold_req(hold_req), .xalu_abort(xalu_abort),
      .out_valid(out_valid), .out_payload(out_payload),
      .out_data(out_data), .park_count(park_count),
      .orphan_err(orphan_err)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [P-1:0] pl;
      logic [D-1:0] dt;
      bit           rdy;
   } ent_t;

   typedef struct {
      bit           v;
      logic [P-1:0] pl;
      logic [D-1:0] dt;
      int           cnt;
      bit           orph;
   } obs_t;

   ent_t mq[$];
   obs_t sb[$];
   bit           mv = 0;
   bit           morph = 0;
   logic [P-1:0] mp = BUB;
   logic [D-1:0] md = '0;
   bit           last_hold = 0;
   int total = 0;
   int bad = 0;

   function automatic void chk(input string nm,
                               input logic [P-1:0] act,
                               input logic [P-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endfunction

   task automatic step(input bit v, input bit mc,
                       input logic [P-1:0] pl, input logic [D-1:0] dt,
                       input bit st, input bit fl, input bit dn,
                       input logic [D-1:0] res, input bit clr);
      int   sz;
      bit   hr;
      bit   eh;
      bit   found;
      obs_t o;
      @(negedge Clk);
      Clr = clr; flush = fl; stall = st;
      in_valid = v; in_mc = mc; in_payload = pl; in_data = dt;
      xalu_done = dn; xalu_result = res;
      sz = mq.size();
      eh = v && ((mc && sz == N) || (!mc && (sz != 0 || st)));
      last_hold = eh;
      #1;
      chk("hold_req", P'(hold_req), P'(eh));
      chk("xalu_abort", P'(xalu_abort), P'(fl));
      if (clr) begin
         mq.delete();
         mv = 0; mp = BUB; md = '0; morph = 0;
      end else if (fl) begin
         mq.delete();
         mv = 0; mp = BUB; md = '0;
      end else begin
         hr = (sz > 0) && mq[0].rdy;
         if (!st) begin
            if (hr) begin
               mv = 1; mp = mq[0].pl; md = mq[0].dt;
            end else if (sz == 0 && v && !mc) begin
               mv = 1; mp = pl; md = dt;
            end else begin
               mv = 0; mp = BUB; md = '0;
            end
         end
         if (dn) begin
            found = 0;
            foreach (mq[i]) begin
               if (!found && !mq[i].rdy) begin
                  mq[i].dt = res; mq[i].rdy = 1; found = 1;
               end
            end
            if (!found) morph = 1;
         end
         if (!st && hr) void'(mq.pop_front());
         if (v && mc && sz < N) mq.push_back('{pl, '0, 1'b0});
      end
      o = '{mv, mp, md, mq.size(), morph};
      sb.push_back(o);
      @(posedge Clk);
   endtask

   task automatic idle(input bit st, input bit dn, input logic [D-1:0] res);
      step(0, 0, '0, '0, st, 0, dn, res, 0);
   endtask

   always @(posedge Clk) begin : mon
      obs_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("out_valid", P'(out_valid), P'(e.v));
         chk("out_payload", out_payload, e.pl);
         chk("out_data", P'(out_data), P'(e.dt));
         chk("park_count", P'(park_count), P'(e.cnt));
         chk("orphan_err", P'(orphan_err), P'(e.orph));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [P-1:0] p_pl;
      logic [D-1:0] p_dt;
      bit p_v, p_mc, st, fl, clr, dn, pend;

      step(0, 0, '0, '0, 0, 0, 0, '0, 1);
      step(0, 0, '0, '0, 0, 0, 0, '0, 1);
      #1;
      chk("rst_valid", P'(out_valid), '0);
      chk("rst_payload", out_payload, 128'h1);
      chk("rst_count", P'(park_count), '0);

      // two single-cycle ops
      step(1, 0, 128'h100, 32'h11, 0, 0, 0, '0, 0);
      #1 chk("t1_first", P'(out_data), 128'h11);
      step(1, 0, 128'h104, 32'h22, 0, 0, 0, '0, 0);
      #1 chk("t1_second", P'(out_data), 128'h22);

      // mc op with 3-cycle XALU latency, single op waiting behind it
      step(1, 1, 128'hBFC00010, '0, 0, 0, 0, '0, 0);
      step(1, 0, 128'h200, 32'h33, 0, 0, 0, '0, 0);
      step(1, 0, 128'h200, 32'h33, 0, 0, 0, '0, 0);
      step(1, 0, 128'h200, 32'h33, 0, 0, 1, 32'hDEADBEEF, 0);
      #1 chk("t2_bubble", P'(out_valid), '0);
      step(1, 0, 128'h200, 32'h33, 0, 0, 0, '0, 0);
      #1;
      chk("t2_valid", P'(out_valid), 128'h1);
      chk("t2_data", P'(out_data), 128'hDEADBEEF);
      chk("t2_pc", out_payload, 128'hBFC00010);
      step(1, 0, 128'h200, 32'h33, 0, 0, 0, '0, 0);
      #1 chk("t2_follow", P'(out_data), 128'h33);

      // three mc ops into two slots
      step(1, 1, 128'hA0, '0, 0, 0, 0, '0, 0);
      step(1, 1, 128'hB0, '0, 0, 0, 0, '0, 0);
      step(1, 1, 128'hC0, '0, 0, 0, 0, '0, 0);
      step(1, 1, 128'hC0, '0, 0, 0, 1, 32'hA, 0);
      step(1, 1, 128'hC0, '0, 0, 0, 1, 32'hB, 0);
      #1;
      chk("t3_a", P'(out_data), 128'hA);
      chk("t3_cnt1", P'(park_count), 128'h1);
      step(1, 1, 128'hC0, '0, 0, 0, 0, '0, 0);
      #1;
      chk("t3_b", P'(out_data), 128'hB);
      chk("t3_cnt2", P'(park_count), 128'h1);
      idle(0, 1, 32'hC);
      idle(0, 0, '0);
      #1 chk("t3_c", P'(out_data), 128'hC);

      // stall while head ready, second result arrives under stall
      step(1, 1, 128'hD0, '0, 0, 0, 0, '0, 0);
      step(1, 1, 128'hD1, '0, 0, 0, 0, '0, 0);
      idle(0, 1, 32'h1);
      idle(1, 1, 32'h2);
      idle(1, 0, '0);
      #1;
      chk("t4_frozen", P'(out_valid), '0);
      chk("t4_cnt2", P'(park_count), 128'h2);
      idle(0, 0, '0);
      #1;
      chk("t4_pop1", P'(out_data), 128'h1);
      chk("t4_cnt1", P'(park_count), 128'h1);
      idle(0, 0, '0);
      #1;
      chk("t4_pop2", P'(out_data), 128'h2);
      chk("t4_cnt0", P'(park_count), '0);

      // flush with a full queue, then a stray result
      step(1, 1, 128'hE0, '0, 1, 0, 0, '0, 0);
      step(1, 1, 128'hE1, '0, 1, 0, 0, '0, 0);
      idle(1, 1, 32'h5);
      step(1, 1, 128'hE2, '0, 0, 1, 0, '0, 0);
      #1;
      chk("t5_cnt", P'(park_count), '0);
      chk("t5_payload", out_payload, 128'h1);
      idle(0, 1, 32'h7);
      #1 chk("t5_orphan", P'(orphan_err), 128'h1);

      // reset while stalled and full
      step(1, 1, 128'hF0, '0, 1, 0, 0, '0, 0);
      step(1, 1, 128'hF1, '0, 1, 0, 0, '0, 0);
      step(1, 1, 128'hF2, '0, 1, 0, 1, 32'h9, 1);
      #1;
      chk("t6_cnt", P'(park_count), '0);
      chk("t6_orphan", P'(orphan_err), '0);
      chk("t6_valid", P'(out_valid), '0);

      p_v = 1; p_mc = 0; p_pl = '0; p_dt = '0;
      for (int k = 0; k < 3000; k++) begin
         st  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 59) == 0);
         clr = ($urandom_range(0, 199) == 0);
         pend = 0;
         foreach (mq[i]) if (!mq[i].rdy) pend = 1;
         dn = pend ? ($urandom_range(0, 9) < 4)
                   : ($urandom_range(0, 299) == 0);
         step(p_v, p_mc, p_pl, p_dt, st, fl, dn, $urandom, clr);
         if (!last_hold || fl || clr) begin
            p_v  = ($urandom_range(0, 9) < 7);
            p_mc = ($urandom_range(0, 9) < 4);
            p_pl = {$urandom, $urandom, $urandom, $urandom};
            p_dt = $urandom;
         end
      end

      idle(0, 0, '0);
      idle(0, 0, '0);
      @(posedge Clk);
      #3;
      chk("sb_drain", P'(sb.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
